// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the register-file write-back arbiter.
package regfile_pkg;

    localparam int NREQ_DEF = 3;
    localparam int AW_DEF   = 4;
    localparam int DW_DEF   = 16;

    // One buffered register write: destination and payload.
    typedef struct packed {
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] data;
    } wb_req_t;

endpackage : regfile_pkg

// File: rtl/rr_arbiter.sv
// Picks one request per cycle and returns a one-hot grant plus its index.
// WB_ROUND_ROBIN_EN defined : round-robin. The search starts one past the last
//                             granted index, and the pointer moves only on a grant.
// WB_ROUND_ROBIN_EN undefined: fixed priority with index 0 highest and no state,
//                             so no clock or reset ports are built.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int SW   = $clog2(NREQ)
) (
`ifdef WB_ROUND_ROBIN_EN
    input  logic            clk,
    input  logic            rst,
`endif
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [SW-1:0]   grant_idx,
    output logic            grant_valid
);

`ifdef WB_ROUND_ROBIN_EN
    logic [SW-1:0] ptr_q;
    int            idx;

    // Scan the requesters starting one past the last winner and grant the first request found.
    always_comb begin
        // NOTE: every output gets a default before the loop, so a path that
        // grants nothing cannot hold an old value and infer a latch.
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!grant_valid && req[idx]) begin
                grant[idx]  = 1'b1;
                grant_idx   = SW'(idx);
                grant_valid = 1'b1;
            end
        end
    end

    // Remember the last winner. The pointer does not move in idle cycles.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments, so every flop
        // samples values from before the edge regardless of process order.
        if (rst) begin
            ptr_q <= '0;
        end else if (grant_valid) begin
            ptr_q <= grant_idx;
        end
    end
`else
    // Fixed priority: the lowest-numbered request wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_valid && req[i]) begin
                grant[i]    = 1'b1;
                grant_idx   = SW'(i);
                grant_valid = 1'b1;
            end
        end
    end
`endif

endmodule : rr_arbiter

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the single write port of the scalar register file.
// Each requester has one holding slot. Each cycle one full slot is granted,
// and its contents are registered onto wb_*. The register file commits them
// on the falling edge of that cycle.
// WB_ROUND_ROBIN_EN selects round-robin arbitration. Without it, requester 0
// has the highest priority.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*AW-1:0]        req_addr,
    input  logic [NREQ*DW-1:0]        req_data,
    output logic                      wb_we,
    output logic [AW-1:0]             wb_addr,
    output logic [DW-1:0]             wb_data,
    output logic [$clog2(NREQ)-1:0]   wb_src,
    output logic [$clog2(NREQ+1)-1:0] pending
);

    localparam int SW = $clog2(NREQ);
    localparam int PW = $clog2(NREQ+1);

    logic [NREQ-1:0] full_q;
    logic [NREQ-1:0] full_d;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] accept;
    logic [AW-1:0]   addr_q [NREQ];
    logic [DW-1:0]   data_q [NREQ];
    logic [SW-1:0]   grant_idx;
    logic            grant_valid;
    logic [PW-1:0]   pending_d;

    // A slot that is draining this cycle can accept a new request at the same edge.
    assign req_ready = ~full_q | grant;
    assign accept    = req_valid & req_ready;
    assign full_d    = accept | (full_q & ~grant);

    rr_arbiter #(.NREQ(NREQ), .SW(SW)) u_arb (
`ifdef WB_ROUND_ROBIN_EN
        .clk         (clk),
        .rst         (rst),
`endif
        .req         (full_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Count the slots that will be occupied after the coming edge.
    always_comb begin
        pending_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            pending_d = pending_d + PW'(full_d[i]);
        end
    end

    // Slot occupancy: reset discards every buffered write.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= '0;
        end else begin
            full_q <= full_d;
        end
    end

    // Slot payload is loaded on accept.
    always_ff @(posedge clk) begin
        // NOTE: the payload arrays have no reset. A slot is only read while
        // its full bit is set, and that bit is cleared by reset.
        for (int i = 0; i < NREQ; i++) begin
            if (accept[i]) begin
                addr_q[i] <= req_addr[i*AW +: AW];
                data_q[i] <= req_data[i*DW +: DW];
            end
        end
    end

    // Registered write port: the granted slot goes out one cycle after the grant. The fields hold while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_we   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
            wb_src  <= '0;
            pending <= '0;
        end else begin
            wb_we   <= grant_valid;
            pending <= pending_d;
            if (grant_valid) begin
                wb_addr <= addr_q[grant_idx];
                wb_data <= data_q[grant_idx];
                wb_src  <= grant_idx;
            end
        end
    end

endmodule : regfile_wb_arbiter
